// File: rtl/des_batch_scheduler_if.sv
// Job issue and result return channel between the batch scheduler (master)
// and the DES core (slave).
interface des_batch_scheduler_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 3
);
  logic              core_valid;
  logic              core_ready;
  logic [DATA_W-1:0] core_key;
  logic [DATA_W-1:0] core_msg;
  logic              core_mode;
  logic [ADDR_W-1:0] core_tag;
  logic              res_valid;
  logic [ADDR_W-1:0] res_tag;
  logic [DATA_W-1:0] res_data;

  modport master (
    output core_valid, core_key, core_msg, core_mode, core_tag,
    input  core_ready, res_valid, res_tag, res_data
  );

  modport slave (
    input  core_valid, core_key, core_msg, core_mode, core_tag,
    output core_ready, res_valid, res_tag, res_data
  );
endinterface

// File: rtl/des_batch_scheduler.sv
// Batch front-end for the DES core: holds up to DEPTH jobs, issues them in index
// order over valid/ready and collects tagged results that may return in any order.
module des_batch_scheduler #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_key,
  input  logic [DATA_W-1:0]     wr_msg,
  input  logic                  wr_mode,
  input  logic                  start,
  input  logic [ADDR_W:0]       count,
  des_batch_scheduler_if.master bus,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_hit,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] key_mem [DEPTH];
  logic [DATA_W-1:0] msg_mem [DEPTH];
  logic              mode_mem [DEPTH];
  logic [DATA_W-1:0] res_mem [DEPTH];
  logic [DEPTH-1:0]  res_vld;

  logic [ADDR_W:0]   issue_idx;
  logic [ADDR_W:0]   rx_cnt;
  logic [ADDR_W:0]   rx_nxt;
  logic [ADDR_W:0]   cnt_reg;
  logic              err_r;

  logic              start_ok;
  logic              start_bad;
  logic              issue_fire;
  logic              res_open;
  logic              res_ok;
  logic              res_bad;
  logic [ADDR_W-1:0] issue_slot;

  logic [DATA_W-1:0] rd_data_p1;
  logic              rd_hit_p1;

  assign issue_slot = issue_idx[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    issue_fire = 1'b0;
    res_ok     = 1'b0;
    res_bad    = 1'b0;
    res_open   = (state == ISSUE) || (state == DRAIN);

    // A result is accepted once per slot and only for slots inside this batch.
    if (res_open && bus.res_valid) begin
      if (({1'b0, bus.res_tag} < cnt_reg) && !res_vld[bus.res_tag]) res_ok  = 1'b1;
      else                                                           res_bad = 1'b1;
    end
    rx_nxt = rx_cnt + {{ADDR_W{1'b0}}, res_ok};

    case (state)
      IDLE: begin
        if (start) begin
          if ((count != '0) && (count <= DEPTH_C)) begin
            start_ok  = 1'b1;
            state_nxt = ISSUE;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      ISSUE: begin
        issue_fire = bus.core_ready;
        if (rx_nxt == cnt_reg)                               state_nxt = DONE;
        else if (issue_fire && (issue_idx == cnt_reg - ONE_C)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (rx_nxt == cnt_reg) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_idx <= '0;
      rx_cnt    <= '0;
      cnt_reg   <= '0;
      res_vld   <= '0;
      err_r     <= 1'b0;
    end else if (start_ok) begin
      issue_idx <= '0;
      rx_cnt    <= '0;
      cnt_reg   <= count;
      res_vld   <= '0;
      err_r     <= 1'b0;
    end else begin
      if (issue_fire) issue_idx <= issue_idx + ONE_C;
      rx_cnt <= rx_nxt;
      if (res_ok) res_vld[bus.res_tag] <= 1'b1;
      if (start_bad || res_bad) err_r <= 1'b1;
    end
  end

  // Job and result storage carry no reset; their contents are only meaningful
  // behind the valid bits and the issue state.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && wr_en) begin
      key_mem[wr_addr]  <= wr_key;
      msg_mem[wr_addr]  <= wr_msg;
      mode_mem[wr_addr] <= wr_mode;
    end
    if (res_ok) res_mem[bus.res_tag] <= bus.res_data;
  end

  // Read stage p1: registered result lookup, zero when the slot holds no result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_p1 <= '0;
      rd_hit_p1  <= 1'b0;
    end else begin
      rd_data_p1 <= res_vld[rd_addr] ? res_mem[rd_addr] : '0;
      rd_hit_p1  <= res_vld[rd_addr];
    end
  end

  assign bus.core_valid = (state == ISSUE);
  assign bus.core_key   = bus.core_valid ? key_mem[issue_slot]  : '0;
  assign bus.core_msg   = bus.core_valid ? msg_mem[issue_slot]  : '0;
  assign bus.core_mode  = bus.core_valid ? mode_mem[issue_slot] : 1'b0;
  assign bus.core_tag   = bus.core_valid ? issue_slot           : '0;

  assign rd_data = rd_data_p1;
  assign rd_hit  = rd_hit_p1;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign err     = err_r;

endmodule

// File: tb/tb_des_batch_scheduler.sv
// Bench for des_batch_scheduler: a behavioural core answers issued jobs with
// random data and a slot-level model predicts issue order, results, done and err.
module tb_des_batch_scheduler;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_key;
  logic [DATA_W-1:0] wr_msg;
  logic              wr_mode;
  logic              start;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_hit;
  logic              busy;
  logic              done;
  logic              err;

  des_batch_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  des_batch_scheduler #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_key(wr_key), .wr_msg(wr_msg), .wr_mode(wr_mode),
    .start(start), .count(count),
    .bus(bus),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_hit(rd_hit),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] m_key [DEPTH];
  logic [DATA_W-1:0] m_msg [DEPTH];
  logic              m_mode [DEPTH];
  logic [DATA_W-1:0] m_res [DEPTH];
  bit                m_hit [DEPTH];
  bit                m_err = 1'b0;
  int                ret_order [$];
  int                dup_tag = -1;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  task automatic load(input int slot, input logic [DATA_W-1:0] k, input logic [DATA_W-1:0] m, input logic md);
    wr_en = 1'b1; wr_addr = slot[ADDR_W-1:0]; wr_key = k; wr_msg = m; wr_mode = md;
    @(negedge clk);
    wr_en = 1'b0;
    m_key[slot] = k; m_msg[slot] = m; m_mode[slot] = md;
  endtask

  task automatic readback();
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = i[ADDR_W-1:0];
      @(negedge clk);
      chkb("rd_hit", rd_hit, m_hit[i]);
      if (m_hit[i]) chk("rd_data", rd_data, m_res[i]);
    end
  endtask

  task automatic bad_start(input int c);
    start = 1'b1; count = c[ADDR_W:0];
    @(negedge clk);
    start = 1'b0;
    m_err = 1'b1;
    chkb("err_bad_start", err, m_err);
    chkb("busy_bad_start", busy, 1'b0);
    @(negedge clk);
    chkb("busy_bad_start_after", busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chkb({tag, "_core_valid"}, bus.core_valid, 1'b0);
    chk ({tag, "_core_key"},   bus.core_key, '0);
    chk ({tag, "_core_msg"},   bus.core_msg, '0);
    chkb({tag, "_core_mode"},  bus.core_mode, 1'b0);
    chk ({tag, "_core_tag"},   64'(bus.core_tag), '0);
    chkb({tag, "_busy"},       busy, 1'b0);
    chkb({tag, "_done"},       done, 1'b0);
    chkb({tag, "_err"},        err, 1'b0);
    chkb({tag, "_rd_hit"},     rd_hit, 1'b0);
    chk ({tag, "_rd_data"},    rd_data, '0);
  endtask

  // lat > 0: in-order echo lat cycles after issue; lat == 0: random out-of-order return.
  task automatic run_batch(input int n, input int lat, input int stall_pct, input int stall_tag,
                           input int stall_len, input bit poke, input int abort_at);
    int issued, rxd, cyc, stalled, sel, t;
    bit exp_done, fin, dup_used, vexp, rdy, dup_now;
    int pt [$];
    int pc [$];
    logic [DATA_W-1:0] rdat;
    issued = 0; rxd = 0; cyc = 0; stalled = 0;
    exp_done = 1'b0; fin = 1'b0; dup_used = 1'b0;
    start = 1'b1; count = n[ADDR_W:0];
    @(negedge clk);
    start = 1'b0;
    m_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_hit[i] = 1'b0;
    while (!fin && cyc < 400) begin
      vexp = (issued < n);
      chkb("busy", busy, 1'b1);
      chkb("done", done, exp_done);
      chkb("err", err, m_err);
      chkb("core_valid", bus.core_valid, vexp);
      if (vexp) begin
        chk ("core_tag",  64'(bus.core_tag), 64'(issued));
        chk ("core_key",  bus.core_key, m_key[issued]);
        chk ("core_msg",  bus.core_msg, m_msg[issued]);
        chkb("core_mode", bus.core_mode, m_mode[issued]);
      end
      if (abort_at > 0 && issued == abort_at) begin
        bus.core_ready = 1'b0; bus.res_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all_zero("mid_rst");
        for (int i = 0; i < DEPTH; i++) m_hit[i] = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        chkb("done_in_rst", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chkb("done_after_rst", done, 1'b0);
        chkb("busy_after_rst", busy, 1'b0);
        return;
      end
      if (exp_done) begin
        bus.res_valid = 1'b0; bus.core_ready = 1'b0; wr_en = 1'b0; start = 1'b0;
        @(negedge clk);
        chkb("done_clear", done, 1'b0);
        chkb("busy_clear", busy, 1'b0);
        fin = 1'b1;
      end else begin
        if (issued == stall_tag && stalled < stall_len) begin
          rdy = 1'b0; stalled++;
        end else begin
          rdy = ($urandom_range(99) >= stall_pct);
        end
        bus.core_ready = rdy;
        wr_en = poke && (cyc == 1);
        start = poke && (cyc == 1);
        if (poke && cyc == 1) begin
          wr_addr = '0; wr_key = ~m_key[0]; wr_msg = ~m_msg[0]; count = 2;
        end
        sel = -1; dup_now = 1'b0;
        if (dup_tag >= 0 && !dup_used && m_hit[dup_tag]) begin
          dup_now = 1'b1;
        end else if (ret_order.size() > 0) begin
          foreach (pt[k]) if (pt[k] == ret_order[0]) sel = k;
        end else if (pt.size() > 0) begin
          if (lat > 0) begin
            if (cyc - pc[0] >= lat) sel = 0;
          end else if ($urandom_range(1) == 1) begin
            sel = int'($urandom_range(pt.size() - 1));
          end
        end
        rdat = {$urandom, $urandom};
        t = dup_now ? dup_tag : ((sel >= 0) ? pt[sel] : 0);
        bus.res_valid = dup_now || (sel >= 0);
        bus.res_tag   = t[ADDR_W-1:0];
        bus.res_data  = rdat;
        @(posedge clk);
        if (vexp && rdy) begin
          pt.push_back(issued); pc.push_back(cyc); issued++;
        end
        if (dup_now) begin
          m_err = 1'b1; dup_used = 1'b1;
        end else if (sel >= 0) begin
          m_res[t] = rdat; m_hit[t] = 1'b1; rxd++;
          pt.delete(sel); pc.delete(sel);
          if (ret_order.size() > 0) void'(ret_order.pop_front());
          if (rxd == n) exp_done = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.res_valid = 1'b0; bus.core_ready = 1'b0; wr_en = 1'b0; start = 1'b0;
    chkb("batch_complete", fin, 1'b1);
  endtask

  initial begin
    wr_en = 1'b0; wr_addr = '0; wr_key = '0; wr_msg = '0; wr_mode = 1'b0;
    start = 1'b0; count = '0; rd_addr = '0;
    bus.core_ready = 1'b0; bus.res_valid = 1'b0; bus.res_tag = '0; bus.res_data = '0;
    #1 rst = 1'b1;
    #2 chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Full batch, in-order echo two cycles after issue.
    for (int i = 0; i < DEPTH; i++) load(i, 64'h133457799BBCDFF1 + 64'(i), {$urandom, $urandom}, i[0]);
    run_batch(8, 2, 0, -1, 0, 1'b0, 0);
    readback();

    // Backpressure on the second job.
    run_batch(3, 0, 0, 1, 4, 1'b0, 0);
    readback();

    // Out-of-order return 3,0,2,1.
    ret_order = '{3, 0, 2, 1};
    run_batch(4, 0, 0, -1, 0, 1'b0, 0);
    readback();

    // Rejected start, then a batch carrying a duplicate tag 2.
    bad_start(0);
    dup_tag = 2;
    ret_order = '{2, 3, 0, 1};
    run_batch(4, 0, 0, -1, 0, 1'b0, 0);
    dup_tag = -1;
    readback();

    // Good start clears err; writes and start while busy are ignored.
    run_batch(5, 0, 30, -1, 0, 1'b1, 0);
    readback();
    run_batch(6, 0, 25, -1, 0, 1'b0, 0);
    readback();

    bad_start(9);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) load(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      run_batch(int'($urandom_range(1, DEPTH)), 0, int'($urandom_range(50)), -1, 0, 1'b0, 0);
      readback();
    end

    // Reset after two of five jobs, then a single-job batch.
    run_batch(5, 1, 0, -1, 0, 1'b0, 2);
    readback();
    load(0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b1);
    run_batch(1, 0, 0, -1, 0, 1'b0, 0);
    readback();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/des_batch_scheduler.md
# des_batch_scheduler

Parametrised batch front-end for the DES datapath. It holds up to DEPTH key/message/mode jobs loaded through a write port, then issues them in index order to a DES core over a valid/ready handshake. Results may return in any order, tagged with the job index, and are stored in a result buffer. This block replaces per-job manual loading of the key and message memories with a single start/done batch, and adds per-job encrypt/decrypt mode selection.

## Interface
- DATA_W, 64, key/message/result width in bits.
- DEPTH, 8, job slots; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), slot index width.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write one job slot.
- wr_addr  in  ADDR_W  slot to write.
- wr_key  in  DATA_W  key for the slot.
- wr_msg  in  DATA_W  message for the slot.
- wr_mode  in  1  0 = encrypt, 1 = decrypt.
- start  in  1  begin a batch (pulse).
- count  in  ADDR_W+1  number of jobs in the batch, 1..DEPTH.
- core_valid  out  1  job is presented to the core.
- core_ready  in  1  core accepts the job.
- core_key, core_msg  out  DATA_W  job operands.
- core_mode  out  1  job mode.
- core_tag  out  ADDR_W  job index.
- res_valid  in  1  core result strobe.
- res_tag  in  ADDR_W  index of the returned job.
- res_data  in  DATA_W  result value.
- rd_addr  in  ADDR_W  result buffer read address.
- rd_data  out  DATA_W  registered result read.
- rd_hit  out  1  the read slot holds a result from the current or last batch.
- busy  out  1  a batch is in progress.
- done  out  1  one-cycle batch-complete pulse.
- err  out  1  sticky error flag; cleared by reset or an accepted start.

## Operation
- **States:** IDLE, ISSUE, DRAIN, DONE.
- **IDLE:**
  - wr_en writes {key, msg, mode} into slot wr_addr.
  - start with count in 1..DEPTH: clears all result-valid bits, clears err, resets issue and receive counters, then moves to ISSUE.
  - start with count = 0 or count > DEPTH: sets err and stays in IDLE.
- **ISSUE:**
  - core_valid = 1. core_* carry slot issue_idx, with core_tag = issue_idx.
  - When core_valid and core_ready are both high, issue_idx increments.
  - When the last job (issue_idx = count-1) is accepted, the state moves to DRAIN.
  - While core_ready is low, core_* hold steady.
- **DRAIN:** core_valid = 0. The block waits for the remaining results.
- **Result handling (ISSUE and DRAIN only):**
  - res_valid with a tag that is below count and not yet valid: store res_data, set its valid bit, increment rx_cnt.
  - res_valid with a tag that is already valid or is ≥ count: set err, leave the data unchanged, do not count it.
  - res_valid in IDLE or DONE: ignored.
- **Completion:** when rx_cnt reaches count, the state moves to DONE. DONE lasts one cycle with done = 1, then returns to IDLE.
- **Busy-time inputs:** busy = 1 in ISSUE, DRAIN and DONE. wr_en and start are ignored while busy. Ignoring them does not set err.
- **Simultaneous events:**
  - An issue handshake and a result in the same cycle are both processed.
  - A result for the last outstanding job arriving in the same cycle as the last issue moves the state directly ISSUE→DONE.
- **Counters:** rx_cnt and issue_idx are ADDR_W+1 bits wide. They never wrap within a batch because count ≤ DEPTH.
- **Result buffer persistence:** contents and valid bits persist after DONE until the next accepted start.

## Timing
- **Reset values:** every output is 0. State is IDLE, all result-valid bits are cleared and err = 0. Job and result storage contents are undefined after reset.
- **Asynchronous reset mid-batch:** abort immediately. Outputs go to reset values in the same cycle. No done pulse is produced.
- **Start latency:**
  - start sampled at edge N.
  - core_valid and busy go high after edge N; core_valid is first observed high at edge N+1.
- **Throughput:** one job per cycle while core_ready is held high. A batch of count jobs with an always-ready core spends exactly count cycles in ISSUE.
- **Done timing:** the last accepted result at edge M gives done = 1 during the cycle after M. busy = 0 and writes are accepted from edge M+2.
- **Read port:** 1-cycle read latency; rd_data and rd_hit reflect rd_addr sampled at the previous edge. A result written at edge K is readable with rd_addr applied at edge K or later, and appears on rd_data after edge K+1.
- **Core outputs:** core_* are driven from registered state. They have no combinational path from core_ready.

## Test plan
- **Full batch, in-order results:** load 8 slots (keys 0x133457799BBCDFF1…, alternating mode), start count=8, core_ready=1, echo each result 2 cycles after issue → 8 consecutive issues with tags 0..7; done once; rd_hit=1 for all 8; rd_data matches the injected results.
- **Backpressure:** count=3, core_ready low for 4 cycles on the 2nd job → core_tag=1, core_key and core_msg stable for those 4 cycles; no duplicate or skipped tag.
- **Out-of-order return:** count=4, results returned with tags 3,0,2,1 → done in the cycle after tag 1 is accepted; each slot holds its own res_data.
- **Errors:**
  - start count=0 → err=1, busy stays 0.
  - A duplicate tag 2 in a batch → err=1, the first data is kept, done occurs only after the genuine remaining tags.
  - A following good start → err clears.
- **Ignored inputs while busy:** wr_en to slot 0 and a second start during ISSUE → slot 0 keeps its original key on the next batch; the batch count is unchanged.
- **Mid-batch reset:** assert rst after 2 of 5 jobs → all outputs 0 immediately, rd_hit=0 for all slots, no done pulse; a new start count=1 completes normally.
